// File: rtl/isa_pkg.sv
// Shared ISA indices and mode tracker state type.
// Imported by the tracker and its helper.
package isa_pkg;

  localparam int ISA_RV  = 0;
  localparam int ISA_ARM = 1;

  typedef enum logic {
    STABLE,
    CANDIDATE
  } state_t;

endpackage

// File: rtl/isa_mode_tracker_if.sv
// Decode-side bundle for the ISA mode tracker.
// master drives decode/force inputs; slave is the tracker.
interface isa_mode_tracker_if #(
  parameter int NISA  = 2,
  parameter int CNTW  = 16,
  parameter int MODEW = $clog2(NISA)
);
  logic [NISA-1:0]  validD;
  logic             instrValidD;
  logic             wasNotFlushed;
  logic             stallD;
  logic             forceEn;
  logic [MODEW-1:0] forceMode;
  logic [MODEW-1:0] modeD;
  logic             illegalD;
  logic             modeSwitchE;
  logic [CNTW-1:0]  switchCount;

  modport master (
    output validD, instrValidD, wasNotFlushed,
    output stallD, forceEn, forceMode,
    input  modeD, illegalD, modeSwitchE, switchCount
  );

  modport slave (
    input  validD, instrValidD, wasNotFlushed,
    input  stallD, forceEn, forceMode,
    output modeD, illegalD, modeSwitchE, switchCount
  );
endinterface

// File: rtl/isa_onehot_pick.sv
// Flags a vector with exactly one bit set and
// returns that bit's index (vec in; single, idx out).
module isa_onehot_pick
  import isa_pkg::*;
#(
  parameter int NISA  = 2,
  parameter int MODEW = $clog2(NISA)
) (
  input  logic [NISA-1:0]  vec,
  output logic             single,
  output logic [MODEW-1:0] idx
);

  assign single = (vec != '0) &&
                  ((vec & (vec - NISA'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NISA; i++)
      if (vec[i]) idx = MODEW'(i);
  end

endmodule

// File: rtl/isa_mode_tracker.sv
// Decode-stage ISA mode tracker with switch hysteresis.
// Ports: clk, reset (sync, high), bus (slave modport).
module isa_mode_tracker
  import isa_pkg::*;
#(
  parameter int NISA       = 2,
  parameter int CONFIRM    = 1,
  parameter int RESET_MODE = ISA_RV,
  parameter int CNTW       = 16,
  parameter int MODEW      = $clog2(NISA)
) (
  input  logic           clk,
  input  logic           reset,
  isa_mode_tracker_if.slave bus
);

  localparam int CW = $clog2(CONFIRM + 1);

  state_t           state_q, state_d;
  logic [MODEW-1:0] mode_q, mode_d;
  logic [MODEW-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    nxt;
  logic             pulse_q;
  logic [CNTW-1:0]  swcnt_q;
  logic [MODEW-1:0] mode_out;
  logic             illegal;
  logic             commit;
  logic             qual;
  logic             hit;
  logic             force_ok;
  logic [NISA-1:0]  others;
  logic             single;
  logic [MODEW-1:0] idx;

  assign qual = bus.instrValidD & bus.wasNotFlushed &
                ~bus.stallD;
  assign hit = bus.validD[mode_q];
  assign others = bus.validD & ~(NISA'(1) << mode_q);
  assign force_ok = bus.forceEn &&
                    (int'(bus.forceMode) < NISA);

  isa_onehot_pick #(
    .NISA  (NISA),
    .MODEW (MODEW)
  ) u_pick (
    .vec    (others),
    .single (single),
    .idx    (idx)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    nxt      = CW'(1);
    commit   = 1'b0;
    mode_out = mode_q;
    illegal  = 1'b0;
    if (qual) begin
      unique case (1'b1)
        hit: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
        (!hit && single): begin
          // Same candidate continues the run;
          // anything else restarts it at one.
          if (state_q == CANDIDATE && cand_q == idx)
            nxt = (cnt_q == CW'(CONFIRM)) ?
                  cnt_q : cnt_q + CW'(1);
          cand_d  = idx;
          state_d = CANDIDATE;
          cnt_d   = nxt;
          if (nxt == CW'(CONFIRM)) begin
            mode_d   = idx;
            mode_out = idx;
            state_d  = STABLE;
            cnt_d    = '0;
            commit   = 1'b1;
          end
        end
        (!hit && !single): begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
      illegal = ~bus.validD[mode_out];
    end
    // Execute redirect overrides decode, even
    // when decode is stalled.
    if (force_ok) begin
      mode_d  = bus.forceMode;
      state_d = STABLE;
      cnt_d   = '0;
      commit  = (bus.forceMode != mode_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STABLE;
      mode_q  <= MODEW'(RESET_MODE);
      cand_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      swcnt_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      pulse_q <= commit;
      if (commit) swcnt_q <= swcnt_q + CNTW'(1);
    end
  end

  assign bus.modeD       = mode_out;
  assign bus.illegalD    = illegal;
  assign bus.modeSwitchE = pulse_q;
  assign bus.switchCount = swcnt_q;

endmodule

// File: tb/tb_isa_mode_tracker.sv
// Bench for isa_mode_tracker: three configurations
// driven together against a run-length reference model.
module tb_isa_mode_tracker;
  import isa_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] v;
  logic       iv, nf, st, fe;
  logic [1:0] fm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  isa_mode_tracker_if #(.NISA(2), .CNTW(16)) ia ();
  isa_mode_tracker_if #(.NISA(3), .CNTW(16)) ib ();
  isa_mode_tracker_if #(.NISA(2), .CNTW(2))  ic ();

  assign ia.validD = v[1:0];
  assign ib.validD = v;
  assign ic.validD = v[1:0];
  assign ia.instrValidD = iv;
  assign ib.instrValidD = iv;
  assign ic.instrValidD = iv;
  assign ia.wasNotFlushed = nf;
  assign ib.wasNotFlushed = nf;
  assign ic.wasNotFlushed = nf;
  assign ia.stallD = st;
  assign ib.stallD = st;
  assign ic.stallD = st;
  assign ia.forceEn = fe;
  assign ib.forceEn = fe;
  assign ic.forceEn = fe;
  assign ia.forceMode = fm[0];
  assign ib.forceMode = fm;
  assign ic.forceMode = fm[0];

  isa_mode_tracker #(
    .NISA(2), .CONFIRM(1), .RESET_MODE(ISA_RV), .CNTW(16)
  ) u_a (.clk(clk), .reset(rst), .bus(ia.slave));

  isa_mode_tracker #(
    .NISA(3), .CONFIRM(3), .RESET_MODE(ISA_RV), .CNTW(16)
  ) u_b (.clk(clk), .reset(rst), .bus(ib.slave));

  isa_mode_tracker #(
    .NISA(2), .CONFIRM(2), .RESET_MODE(ISA_ARM), .CNTW(2)
  ) u_c (.clk(clk), .reset(rst), .bus(ic.slave));

  int conf[3]  = '{1, 3, 2};
  int nisa[3]  = '{2, 3, 2};
  int cntw[3]  = '{16, 16, 2};
  int rmode[3] = '{0, 0, 1};

  // Model: committed mode, plus the current run of
  // consecutive instructions legal only in one other ISA.
  int m_mode[3], m_risa[3], m_rlen[3];
  int m_pulse[3], m_cnt[3];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_init();
    for (int k = 0; k < 3; k++) begin
      m_mode[k]  = rmode[k];
      m_risa[k]  = 0;
      m_rlen[k]  = 0;
      m_pulse[k] = 0;
      m_cnt[k]   = 0;
    end
  endtask

  task automatic model(input int k,
                       output int md, output int il);
    int vm, fk, pc, c, nl, commit, nm;
    bit q;
    vm = int'(v) & ((1 << nisa[k]) - 1);
    fk = (k == 1) ? int'(fm) : int'(fm[0]);
    q  = iv && nf && !st;
    md = m_mode[k];
    il = 0;
    commit = 0;
    nm = m_mode[k];
    if (q) begin
      if (((vm >> m_mode[k]) & 1) == 1) begin
        m_rlen[k] = 0;
      end else begin
        pc = 0;
        c = 0;
        for (int i = 0; i < nisa[k]; i++)
          if (((vm >> i) & 1) == 1) begin
            pc++;
            c = i;
          end
        if (pc == 1) begin
          nl = (m_rlen[k] > 0 && m_risa[k] == c) ?
               m_rlen[k] + 1 : 1;
          if (nl == conf[k]) begin
            md = c;
            nm = c;
            commit = 1;
            m_rlen[k] = 0;
          end else begin
            m_risa[k] = c;
            m_rlen[k] = nl;
          end
        end else begin
          m_rlen[k] = 0;
        end
      end
      il = (((vm >> md) & 1) == 0) ? 1 : 0;
    end
    if (fe && fk < nisa[k]) begin
      commit = (fk != m_mode[k]) ? 1 : 0;
      nm = fk;
      m_rlen[k] = 0;
    end
    if (rst) begin
      m_mode[k]  = rmode[k];
      m_rlen[k]  = 0;
      m_pulse[k] = 0;
      m_cnt[k]   = 0;
    end else begin
      m_mode[k]  = nm;
      m_pulse[k] = commit;
      if (commit == 1)
        m_cnt[k] = (m_cnt[k] + 1) % (1 << cntw[k]);
    end
  endtask

  // Called just after a falling edge with inputs set;
  // returns at the next falling edge.
  task automatic step();
    logic [31:0] gm, gi, gp, gc;
    int md, il;
    #1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin
          gm = 32'(ia.modeD); gi = 32'(ia.illegalD);
          gp = 32'(ia.modeSwitchE);
          gc = 32'(ia.switchCount);
        end
        1: begin
          gm = 32'(ib.modeD); gi = 32'(ib.illegalD);
          gp = 32'(ib.modeSwitchE);
          gc = 32'(ib.switchCount);
        end
        default: begin
          gm = 32'(ic.modeD); gi = 32'(ic.illegalD);
          gp = 32'(ic.modeSwitchE);
          gc = 32'(ic.switchCount);
        end
      endcase
      check($sformatf("pulse%0d", k), gp, 32'(m_pulse[k]));
      check($sformatf("count%0d", k), gc, 32'(m_cnt[k]));
      model(k, md, il);
      check($sformatf("modeD%0d", k), gm, 32'(md));
      check($sformatf("illegal%0d", k), gi, 32'(il));
    end
    @(negedge clk);
  endtask

  task automatic idle();
    v = 3'b000; iv = 1'b0; nf = 1'b1;
    st = 1'b0; fe = 1'b0; fm = 2'b00;
  endtask

  task automatic issue(input logic [2:0] val);
    v = val; iv = 1'b1; nf = 1'b1;
    st = 1'b0; fe = 1'b0;
    step();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [1:0] wrap_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_init();
    rst = 1'b0;

    // immediate switch with CONFIRM=1
    do_reset();
    issue(3'b010);
    check("a_pulse_after", 32'(ia.modeSwitchE), 32'd1);
    check("a_count_after", 32'(ia.switchCount), 32'd1);

    // CONFIRM=3 run broken by a native instruction
    do_reset();
    issue(3'b010);
    issue(3'b010);
    issue(3'b001);
    issue(3'b010);
    issue(3'b010);
    check("b_no_switch_yet", 32'(ib.switchCount), 32'd0);
    issue(3'b010);
    check("b_switch_6th", 32'(ib.switchCount), 32'd1);
    check("b_pulse_6th", 32'(ib.modeSwitchE), 32'd1);

    // stall and bubble do not break the run
    do_reset();
    issue(3'b001);
    v = 3'b001; iv = 1'b1; nf = 1'b1; st = 1'b1;
    step();
    st = 1'b0; nf = 1'b0;
    step();
    issue(3'b001);
    check("c_switch", 32'(ic.switchCount), 32'd1);
    check("c_mode", 32'(ic.modeD), 32'(ISA_RV));

    // no legal decode, then both legal
    do_reset();
    issue(3'b000);
    issue(3'b011);

    // forced change while stalled mid-candidate
    do_reset();
    issue(3'b001);
    v = 3'b001; iv = 1'b1; st = 1'b1;
    fe = 1'b1; fm = 2'b00;
    step();
    check("c_force_pulse", 32'(ic.modeSwitchE), 32'd1);
    check("a_force_same", 32'(ia.modeSwitchE), 32'd0);
    check("c_force_mode", 32'(ic.modeD), 32'd0);
    idle();
    step();

    // counter wrap with CNTW=2, then reset mid-run
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fe = 1'b1;
      fm = (i % 2 == 0) ? 2'b00 : 2'b01;
      step();
      check($sformatf("c_wrap%0d", i),
            32'(ic.switchCount), 32'(wrap_exp[i]));
    end
    idle();
    issue(3'b010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("c_rst_mode", 32'(ic.modeD), 32'(ISA_ARM));
    check("c_rst_count", 32'(ic.switchCount), 32'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      v  = 3'($urandom);
      iv = ($urandom % 8) != 0;
      nf = ($urandom % 8) != 0;
      st = ($urandom % 6) == 0;
      fe = ($urandom % 10) == 0;
      fm = 2'($urandom);
      if (fe && fm == 2'b11) st = 1'b1;
      rst = ($urandom % 97) == 0;
      step();
    end
    idle();
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
